// File: rtl/gcn_pkg.sv
// ---------------------------------------------------------------------------
// gcn_pkg
// Shared sizing constants and FSM state encoding for the GCN aggregation
// datapath. The aggregation engine and the arg_max stage that follows it
// both import this package, so they agree on row and column geometry.
// ---------------------------------------------------------------------------
package gcn_pkg;

    localparam int BW        = 21;  // width of one feature/accumulator element
    localparam int NUM_NODES = 6;   // graph nodes (rows)
    localparam int NUM_COLS  = 3;   // feature columns (classes)
    localparam int NUM_EDGES = 6;   // COO edge entries processed per run
    localparam int NODE_W    = 3;   // width of one node index

    // State encodings are plain constants so older tools and other
    // code that compares raw state values keep working.
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_CLEAR   = 3'd1;
    localparam state_t ST_EDGE_RD = 3'd2;
    localparam state_t ST_SRC_RD  = 3'd3;
    localparam state_t ST_DST_RD  = 3'd4;
    localparam state_t ST_ACC     = 3'd5;
    localparam state_t ST_DONE    = 3'd6;

    // Returns 1 when a node index addresses a real row.
    function automatic logic node_in_range(input logic [NODE_W-1:0] idx);
        return (32'(idx) < 32'(NUM_NODES));
    endfunction

endpackage

// File: rtl/sat_add.sv
// ---------------------------------------------------------------------------
// sat_add
// Unsigned BW-bit adder that clamps to all-ones on overflow. Wrap-around
// would make a large accumulated score look small to arg_max, so the sum
// is clamped.
//   i_a, i_b : addends
//   o_sum    : min(i_a + i_b, 2**BW-1)
// ---------------------------------------------------------------------------
module sat_add #(
    parameter int BW = 21
) (
    input  logic [BW-1:0] i_a,
    input  logic [BW-1:0] i_b,
    output logic [BW-1:0] o_sum
);

    logic [BW:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b};
    assign o_sum  = w_full[BW] ? {BW{1'b1}} : w_full[BW-1:0];

endmodule

// File: rtl/aggregation_engine.sv
// ---------------------------------------------------------------------------
// aggregation_engine
// Walks a COO edge list and, for every undirected edge {src,dst}, adds the
// feature row of dst into accumulator row src and the row of src into
// accumulator row dst. Each edge takes exactly four cycles. A run takes
// 4*NUM_EDGES+2 cycles from start to done.
//
// Ports
//   clk, rst_n         : clock, synchronous active-low reset
//   start              : one-cycle run request, honoured only when idle
//   coo_addr / coo_in  : edge memory, {src,dst} returned one cycle later
//   fm_wb_addr /
//   fm_wb_row          : feature memory, row returned one cycle later
//   aggregation_output : accumulated rows [node][col], held between runs
//   done               : one-cycle pulse closing a run
//   busy               : high for the whole run including the done cycle
//   edge_err           : sticky per run, an edge had an out-of-range node
// ---------------------------------------------------------------------------
module aggregation_engine #(
    parameter int BW        = gcn_pkg::BW,
    parameter int NUM_NODES = gcn_pkg::NUM_NODES,
    parameter int NUM_COLS  = gcn_pkg::NUM_COLS,
    parameter int NUM_EDGES = gcn_pkg::NUM_EDGES,
    parameter int NODE_W    = gcn_pkg::NODE_W
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       start,
    output logic [$clog2(NUM_EDGES)-1:0]               coo_addr,
    input  logic [2*NODE_W-1:0]                        coo_in,
    output logic [NODE_W-1:0]                          fm_wb_addr,
    input  logic [NUM_COLS*BW-1:0]                     fm_wb_row,
    output logic [NUM_NODES-1:0][NUM_COLS-1:0][BW-1:0] aggregation_output,
    output logic                                       done,
    output logic                                       busy,
    output logic                                       edge_err
);

    import gcn_pkg::*;

    localparam int EW = $clog2(NUM_EDGES);

    // ---------------- registers ----------------
    state_t                                      r_state;
    logic [EW-1:0]                               r_edge_idx;
    logic [EW-1:0]                               r_coo_addr;
    logic [NODE_W-1:0]                           r_src;
    logic [NODE_W-1:0]                           r_dst;
    logic [NUM_COLS-1:0][BW-1:0]                 r_row_src;
    logic [NUM_NODES-1:0][NUM_COLS-1:0][BW-1:0]  r_out;
    logic                                        r_done;
    logic                                        r_busy;
    logic                                        r_edge_err;

    // ---------------- wires ----------------
    state_t                                      w_next;
    logic [EW-1:0]                               w_next_edge_idx;
    logic                                        w_last;
    logic [NODE_W-1:0]                           w_coo_src;
    logic                                        w_src_ok;
    logic                                        w_dst_ok;
    logic                                        w_edge_ok;
    logic [NODE_W-1:0]                           w_src_idx;
    logic [NODE_W-1:0]                           w_dst_idx;
    logic [NUM_COLS-1:0][BW-1:0]                 w_row_cur;
    logic [NUM_COLS-1:0][BW-1:0]                 w_sum_src;
    logic [NUM_COLS-1:0][BW-1:0]                 w_sum_dst;
    logic [NODE_W-1:0]                           w_fm_addr;

    assign w_last    = (r_edge_idx == EW'(NUM_EDGES - 1));
    assign w_coo_src = coo_in[2*NODE_W-1:NODE_W];
    assign w_row_cur = fm_wb_row;

    assign w_src_ok  = (32'(r_src) < 32'(NUM_NODES));
    assign w_dst_ok  = (32'(r_dst) < 32'(NUM_NODES));
    assign w_edge_ok = w_src_ok & w_dst_ok;

    // Invalid indices are steered to row 0 so the adders never read
    // outside the accumulator array. Their sums are discarded anyway.
    assign w_src_idx = w_src_ok ? r_src : {NODE_W{1'b0}};
    assign w_dst_idx = w_dst_ok ? r_dst : {NODE_W{1'b0}};

    // Two update paths per column: the src row gains the dst features, and
    // the dst row gains the src features.
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        sat_add #(.BW(BW)) u_add_src (
            .i_a   (r_out[w_src_idx][c]),
            .i_b   (w_row_cur[c]),
            .o_sum (w_sum_src[c])
        );
        sat_add #(.BW(BW)) u_add_dst (
            .i_a   (r_out[w_dst_idx][c]),
            .i_b   (r_row_src[c]),
            .o_sum (w_sum_dst[c])
        );
    end

    // Next-state logic for the per-edge sequence.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_CLEAR;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_CLEAR:   w_next = ST_EDGE_RD;
            ST_EDGE_RD: w_next = ST_SRC_RD;
            ST_SRC_RD:  w_next = ST_DST_RD;
            ST_DST_RD:  w_next = ST_ACC;
            ST_ACC: begin
                if (w_last) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_EDGE_RD;
                end
            end
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Edge index to be used next. Computed here so coo_addr can be
    // registered one cycle ahead of the EDGE_RD state.
    always_comb begin
        w_next_edge_idx = r_edge_idx;
        case (r_state)
            ST_CLEAR: w_next_edge_idx = {EW{1'b0}};
            ST_ACC: begin
                if (w_last) begin
                    w_next_edge_idx = r_edge_idx;
                end else begin
                    w_next_edge_idx = r_edge_idx + EW'(1);
                end
            end
            default:  w_next_edge_idx = r_edge_idx;
        endcase
    end

    // Feature read address. In SRC_RD the src index arrives on coo_in in
    // that same cycle, so this path is combinational to keep four cycles
    // per edge.
    always_comb begin
        w_fm_addr = {NODE_W{1'b0}};
        case (r_state)
            ST_SRC_RD: w_fm_addr = w_coo_src;
            ST_DST_RD: w_fm_addr = r_dst;
            default:   w_fm_addr = {NODE_W{1'b0}};
        endcase
    end

    // State, edge index and registered status and address outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_edge_idx <= {EW{1'b0}};
            r_coo_addr <= {EW{1'b0}};
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_edge_idx <= w_next_edge_idx;
            r_coo_addr <= (w_next == ST_EDGE_RD) ? w_next_edge_idx : {EW{1'b0}};
            r_done     <= (w_next == ST_DONE);
            r_busy     <= (w_next != ST_IDLE);
        end
    end

    // Latch the current edge endpoints and the src feature row.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_src     <= {NODE_W{1'b0}};
            r_dst     <= {NODE_W{1'b0}};
            r_row_src <= '0;
        end else begin
            case (r_state)
                ST_SRC_RD: begin
                    r_src <= w_coo_src;
                    r_dst <= coo_in[NODE_W-1:0];
                end
                ST_DST_RD: r_row_src <= fm_wb_row;
                default: begin
                    r_src     <= r_src;
                    r_dst     <= r_dst;
                    r_row_src <= r_row_src;
                end
            endcase
        end
    end

    // Accumulator array and sticky edge error flag. A self-loop writes the
    // src path only, so the row is added once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out      <= '0;
            r_edge_err <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_out      <= '0;
                    r_edge_err <= 1'b0;
                end
                ST_ACC: begin
                    if (w_edge_ok) begin
                        for (int c = 0; c < NUM_COLS; c++) begin
                            r_out[w_src_idx][c] <= w_sum_src[c];
                            if (r_src != r_dst) begin
                                r_out[w_dst_idx][c] <= w_sum_dst[c];
                            end
                        end
                    end else begin
                        r_edge_err <= 1'b1;
                    end
                end
                default: begin
                    r_out      <= r_out;
                    r_edge_err <= r_edge_err;
                end
            endcase
        end
    end

    assign coo_addr           = r_coo_addr;
    assign fm_wb_addr         = w_fm_addr;
    assign aggregation_output = r_out;
    assign done               = r_done;
    assign busy               = r_busy;
    assign edge_err           = r_edge_err;

endmodule

// File: tb/tb_aggregation_engine.sv
// ---------------------------------------------------------------------------
// tb_aggregation_engine
// Directed bench: synchronous-read edge and feature memories surround the
// engine, and each scenario loads them and then compares results against
// hand-computed rows.
// ---------------------------------------------------------------------------
module tb_aggregation_engine;

    localparam int BW        = 21;
    localparam int NUM_NODES = 6;
    localparam int NUM_COLS  = 3;
    localparam int NUM_EDGES = 6;
    localparam int NODE_W    = 3;
    localparam int EW        = $clog2(NUM_EDGES);
    localparam int RW        = NUM_COLS * BW;
    localparam int LATENCY   = 4 * NUM_EDGES + 2;
    localparam logic [BW-1:0] MAXV = {BW{1'b1}};

    logic                                       clk;
    logic                                       rst_n;
    logic                                       start;
    logic [EW-1:0]                              coo_addr;
    logic [2*NODE_W-1:0]                        coo_in;
    logic [NODE_W-1:0]                          fm_wb_addr;
    logic [RW-1:0]                              fm_wb_row;
    logic [NUM_NODES-1:0][NUM_COLS-1:0][BW-1:0] aggregation_output;
    logic                                       done;
    logic                                       busy;
    logic                                       edge_err;

    logic [2*NODE_W-1:0] coo_mem [NUM_EDGES];
    logic [RW-1:0]       fm_mem  [8];
    logic [RW-1:0]       exp_rows [NUM_NODES];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    aggregation_engine dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .coo_addr           (coo_addr),
        .coo_in             (coo_in),
        .fm_wb_addr         (fm_wb_addr),
        .fm_wb_row          (fm_wb_row),
        .aggregation_output (aggregation_output),
        .done               (done),
        .busy               (busy),
        .edge_err           (edge_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memories with one cycle of read latency.
    always @(posedge clk) begin
        coo_in    <= (32'(coo_addr) < 32'(NUM_EDGES)) ? coo_mem[coo_addr] : '0;
        fm_wb_row <= fm_mem[fm_wb_addr];
    end

    function automatic logic [RW-1:0] mkrow(input logic [BW-1:0] a,
                                            input logic [BW-1:0] b,
                                            input logic [BW-1:0] c);
        return {c, b, a};
    endfunction

    function automatic logic [2*NODE_W-1:0] mkedge(input int s, input int d);
        logic [NODE_W-1:0] ls;
        logic [NODE_W-1:0] ld;
        ls = NODE_W'(s);
        ld = NODE_W'(d);
        return {ls, ld};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rows(input string tag);
        for (int n = 0; n < NUM_NODES; n++) begin
            chk($sformatf("%s_out%0d", tag, n), 64'(aggregation_output[n]), 64'(exp_rows[n]));
        end
    endtask

    task automatic clear_mems();
        for (int i = 0; i < NUM_EDGES; i++) coo_mem[i] = mkedge(4, 5);  // zero rows: no effect
        for (int i = 0; i < 8; i++) fm_mem[i] = '0;
        for (int i = 0; i < NUM_NODES; i++) exp_rows[i] = '0;
    endtask

    task automatic load_basic();
        clear_mems();
        coo_mem[0] = mkedge(0, 1);
        coo_mem[1] = mkedge(1, 2);
        fm_mem[0]  = mkrow(21'd1, 21'd2, 21'd3);
        fm_mem[1]  = mkrow(21'd10, 21'd20, 21'd30);
        fm_mem[2]  = mkrow(21'd100, 21'd200, 21'd300);
        exp_rows[0] = mkrow(21'd10, 21'd20, 21'd30);
        exp_rows[1] = mkrow(21'd101, 21'd202, 21'd303);
        exp_rows[2] = mkrow(21'd10, 21'd20, 21'd30);
    endtask

    // Start a run and check busy, the done latency and the return to idle.
    task automatic run(input string tag);
        int cyc;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 1;
        chk({tag, "_busy_first"}, 64'(busy), 64'd1);
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(LATENCY));
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_busy_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int dones;
        rst_n = 1'b0;
        start = 1'b1;   // reset must win over start
        clear_mems();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(edge_err), 64'd0);
        chk("rst_coo_addr", 64'(coo_addr), 64'd0);
        chk("rst_fm_addr", 64'(fm_wb_addr), 64'd0);
        chk_rows("rst");
        @(negedge clk);
        chk("rst_start_ignored", 64'(busy), 64'd0);

        // Two chained edges
        load_basic();
        run("basic");
        chk_rows("basic");
        chk("basic_err", 64'(edge_err), 64'd0);
        chk("idle_coo_addr", 64'(coo_addr), 64'd0);
        chk("idle_fm_addr", 64'(fm_wb_addr), 64'd0);
        repeat (3) @(negedge clk);
        chk_rows("basic_hold");

        // Self-loop adds row once
        clear_mems();
        coo_mem[0]  = mkedge(3, 3);
        fm_mem[3]   = mkrow(21'd5, 21'd6, 21'd7);
        exp_rows[3] = mkrow(21'd5, 21'd6, 21'd7);
        run("selfloop");
        chk_rows("selfloop");

        // Out-of-range src and dst are skipped; valid edge still applied
        clear_mems();
        coo_mem[0] = mkedge(7, 0);
        coo_mem[1] = mkedge(0, 1);
        coo_mem[2] = mkedge(2, 6);
        fm_mem[0]  = mkrow(21'd1, 21'd2, 21'd3);
        fm_mem[1]  = mkrow(21'd10, 21'd20, 21'd30);
        fm_mem[2]  = mkrow(21'd100, 21'd200, 21'd300);
        fm_mem[6]  = mkrow(21'd8, 21'd8, 21'd8);
        fm_mem[7]  = mkrow(21'd9, 21'd9, 21'd9);
        exp_rows[0] = mkrow(21'd10, 21'd20, 21'd30);
        exp_rows[1] = mkrow(21'd1, 21'd2, 21'd3);
        run("range");
        chk_rows("range");
        chk("range_err", 64'(edge_err), 64'd1);
        repeat (2) @(negedge clk);
        chk("range_err_hold", 64'(edge_err), 64'd1);

        // Saturation, and edge_err cleared by the new run
        clear_mems();
        coo_mem[0] = mkedge(0, 1);
        coo_mem[1] = mkedge(0, 1);
        fm_mem[0]  = mkrow(MAXV, 21'd1, 21'd0);
        fm_mem[1]  = mkrow(21'd3, 21'd4, 21'd5);
        exp_rows[0] = mkrow(21'd6, 21'd8, 21'd10);
        exp_rows[1] = mkrow(MAXV, 21'd2, 21'd0);
        run("sat");
        chk_rows("sat");
        chk("sat_err_cleared", 64'(edge_err), 64'd0);

        // Reset during DST_RD of edge 1 (cycle 8 after start)
        load_basic();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        for (int n = 0; n < NUM_NODES; n++) exp_rows[n] = '0;
        chk_rows("midrst");
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        chk("midrst_no_done", 64'(dones), 64'd0);
        load_basic();
        run("after_rst");
        chk_rows("after_rst");

        // Start while busy is ignored: exactly one done
        load_basic();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        dones = 0;
        for (int i = 1; i < 40; i++) begin
            if (i == 5) start = 1'b1;
            if (i == 6) start = 1'b0;
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        chk("busy_start_one_done", 64'(dones), 64'd1);
        chk_rows("busy_start");
        run("rerun");
        chk_rows("rerun");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/aggregation_engine.md
AGGREGATION_ENGINE -- requirements
Module: aggregation_engine

Interface
REQ-001 SHALL have parameter BW, 21, unsigned width of each feature/accumulator element.
REQ-002 SHALL have parameter NUM_NODES, 6, number of graph nodes (rows).
REQ-003 SHALL have parameter NUM_COLS, 3, number of feature columns (classes).
REQ-004 SHALL have parameter NUM_EDGES, 6, number of COO edge entries processed per run.
REQ-005 SHALL have parameter NODE_W, 3, width of one node index; NUM_NODES ≤ 2**NODE_W.
REQ-006 SHALL use one clock and a synchronous, active-low reset.
REQ-007 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-008 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-009 SHALL have port start, input, 1, single-cycle run request.
REQ-010 SHALL have port coo_addr, output, $clog2(NUM_EDGES), edge-memory read address.
REQ-011 SHALL have port coo_in, input, 2*NODE_W, edge-memory read data {src, dst}; valid one cycle after its address.
REQ-012 SHALL have port fm_wb_addr, output, NODE_W, feature-row read address.
REQ-013 SHALL have port fm_wb_row, input, NUM_COLS*BW, feature-row read data (column 0 in LSBs); valid one cycle after its address.
REQ-014 SHALL have port aggregation_output, output, [NUM_NODES][NUM_COLS] x BW, accumulated rows feeding arg_max.
REQ-015 SHALL have port done, output, 1, one-cycle pulse at run end; drives arg_max max_start.
REQ-016 SHALL have port busy, output, 1, high from the cycle after accepted start until the done cycle inclusive.
REQ-017 SHALL have port edge_err, output, 1, sticky per run: an edge with an out-of-range index was skipped.

Function
REQ-018 SHALL implement FSM states IDLE, CLEAR, EDGE_RD, SRC_RD, DST_RD, ACC, DONE.
REQ-019 SHALL move IDLE→CLEAR on start; start in any other state SHALL be ignored.
REQ-020 CLEAR SHALL zero every aggregation_output element, clear edge_err, set edge index 0, and go to EDGE_RD.
REQ-021 EDGE_RD SHALL drive coo_addr=edge index and go to SRC_RD.
REQ-022 SRC_RD SHALL latch {src,dst} from coo_in, drive fm_wb_addr=src, and go to DST_RD.
REQ-023 DST_RD SHALL latch fm_wb_row as row_src, drive fm_wb_addr=dst, and go to ACC.
REQ-024 ACC SHALL use fm_wb_row as row_dst: out[src][c] += row_dst[c] and out[dst][c] += row_src[c] for all c; exactly 4 cycles per edge.
REQ-025 When src==dst, ACC SHALL add the row once only (self-loop).
REQ-026 When src or dst ≥ NUM_NODES, ACC SHALL leave all accumulators unchanged and set edge_err.
REQ-027 Additions SHALL be unsigned and saturate at 2**BW-1; no wrap-around.
REQ-028 After ACC of edge NUM_EDGES-1 the FSM SHALL go to DONE; otherwise it SHALL increment the edge index and go to EDGE_RD.
REQ-029 DONE SHALL assert done for one cycle and return to IDLE; total latency from start to done = 4*NUM_EDGES+2 cycles.
REQ-030 aggregation_output and edge_err SHALL hold their values in IDLE until the next CLEAR.
REQ-031 coo_addr and fm_wb_addr SHALL be 0 in IDLE.

Reset
REQ-032 rst_n low at a clock edge SHALL force IDLE, zero all aggregation_output, done=0, busy=0, edge_err=0, coo_addr=0, fm_wb_addr=0, edge index 0.
REQ-033 Reset mid-run SHALL abandon the run with no done pulse; a later start SHALL begin a fresh run.
REQ-034 Reset SHALL dominate a simultaneous start.

Structure
REQ-035 SHALL take BW, NUM_NODES, NUM_COLS, NUM_EDGES, NODE_W and the FSM state enum from shared package gcn_pkg.
REQ-036 SHALL instantiate sub-module sat_add (BW-bit unsigned saturating adder), one per column per update path.

Verification
REQ-037 Edges {0,1},{1,2}; row0=(1,2,3), row1=(10,20,30), row2=(100,200,300) → out0=(10,20,30), out1=(101,202,303), out2=(10,20,30); done at cycle 4*NUM_EDGES+2 after start.
REQ-038 Self-loop {3,3}, row3=(5,6,7), no other edges touching node 3 → out3=(5,6,7), not doubled.
REQ-039 Edge {7,0} with NUM_NODES=6 → edge_err=1, all outputs unchanged by that edge, run still completes with done.
REQ-040 row0=(2**BW-1,1,0) on edge {0,1} twice → out1[0] saturates at 2**BW-1, out1[1]=2.
REQ-041 rst_n low for one cycle mid-run in DST_RD → next cycle busy=0, outputs zero, no done; following start gives correct result.
REQ-042 start pulsed again while busy → ignored; exactly one done pulse; second run after IDLE reproduces identical outputs.
